// File: rtl/memory_stage_pkg.sv
// Shared types and default constants for the memory stage and its data memory.
package memory_stage_pkg;

    localparam int              ADDR_W_DEFAULT  = 12;
    localparam logic [11:0]     SP_INIT_DEFAULT = 12'hFFF;

    typedef enum logic [1:0] {
        ADDR_RESULT = 2'b00,
        ADDR_STACK  = 2'b01
    } addr_sel_e;

    typedef enum logic [1:0] {
        WSRC_RDEST = 2'b00,
        WSRC_PC    = 2'b01
    } wsrc_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } mem_state_e;

endpackage

// File: rtl/memory_stage_data_memory.sv
// 16-bit wide data memory: one synchronous write port, one combinational read port.
module data_memory
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o
);

    // The array is deliberately left without a reset.
    logic [15:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: loads/stores, stack pointer with 16/32-bit push/pop,
// and the MEM/WB buffer feeding write-back.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result,
    input  logic [15:0]       read_data1,
    input  logic [31:0]       pc_plus_one,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic              pc_choose_memory,
    input  logic              reg_write,
    input  logic              outport_enable,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        reg_write_address,
    input  logic [15:0]       LDM_value,
    input  logic [15:0]       input_port,
    output logic              stall,
    output logic [31:0]       pc_from_mem,
    output logic              pc_from_mem_valid,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       result_out,
    output logic [15:0]       LDM_value_out,
    output logic [15:0]       input_port_out,
    output logic              reg_write_out,
    output logic              outport_enable_out,
    output logic [1:0]        wb_sel_out,
    output logic [2:0]        reg_write_address_out,
    output logic [ADDR_W-1:0] sp_out,
    output mem_state_e        state_out
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              op_pop_q, op_pop_d;
    logic [15:0]       low_q, low_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic [31:0]       pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;

    logic [15:0]       result_q, ldm_q, inport_q;
    logic              reg_write_q, outport_en_q;
    logic [1:0]        wb_sel_q;
    logic [2:0]        rwa_q;

    logic [ADDR_W-1:0] sp_inc, sp_dec, res_addr;
    logic              do_push, do_pop, do_write, do_read;
    logic              push32, pop32, sel_stack;
    logic              we, bubble;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [15:0]       wdata, rdata;

    logic unused_result_bits;
    assign unused_result_bits = &{1'b0, result[15:ADDR_W]};

    assign sp_inc    = sp_q + ADDR_W'(1);
    assign sp_dec    = sp_q - ADDR_W'(1);
    assign res_addr  = result[ADDR_W-1:0];
    assign sel_stack = (memory_address_select == ADDR_STACK);

    // Strobe priority: push > pop > write > read.
    assign do_push  = mem_push;
    assign do_pop   = mem_pop & ~mem_push;
    assign do_write = mem_write & ~mem_push & ~mem_pop;
    assign do_read  = mem_read & ~mem_push & ~mem_pop & ~mem_write;
    assign push32   = do_push & (memory_write_src_select == WSRC_PC);
    assign pop32    = do_pop & pc_choose_memory;

    // Handshake: stall=1 asks EX/MEM to hold the same op for one more cycle;
    // the held op is then completed as word 2 in SECOND with stall=0.
    assign stall = reset & (state_q == IDLE) & (push32 | pop32);

    // Read address kept separate from the main next-state block so the
    // combinational read data never loops back into its own address.
    assign raddr = ((state_q == SECOND) | do_pop | sel_stack) ? sp_inc : res_addr;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        op_pop_d   = op_pop_q;
        low_d      = low_q;
        mem_data_d = mem_data_q;
        pc_d       = pc_q;
        pc_valid_d = 1'b0;
        we         = 1'b0;
        waddr      = res_addr;
        wdata      = read_data1;
        bubble     = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_push) begin
                    we    = 1'b1;
                    waddr = sp_q;
                    wdata = push32 ? pc_plus_one[31:16] : read_data1;
                    sp_d  = sp_dec;
                    if (push32) begin
                        state_d  = SECOND;
                        op_pop_d = 1'b0;
                        bubble   = 1'b1;
                    end
                end else if (do_pop) begin
                    sp_d = sp_inc;
                    if (pop32) begin
                        low_d    = rdata;
                        state_d  = SECOND;
                        op_pop_d = 1'b1;
                        bubble   = 1'b1;
                    end else begin
                        mem_data_d = rdata;
                    end
                end else if (do_write) begin
                    we    = 1'b1;
                    waddr = sel_stack ? sp_q : res_addr;
                end else if (do_read) begin
                    mem_data_d = rdata;
                end
            end
            SECOND: begin
                state_d = IDLE;
                if (op_pop_q) begin
                    sp_d       = sp_inc;
                    pc_d       = {rdata, low_q};
                    pc_valid_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = sp_q;
                    wdata = pc_plus_one[15:0];
                    sp_d  = sp_dec;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .clk_i   (clk),
        .we_i    (we & reset),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sp_q         <= SP_INIT;
            op_pop_q     <= 1'b0;
            low_q        <= '0;
            mem_data_q   <= '0;
            pc_q         <= '0;
            pc_valid_q   <= 1'b0;
            result_q     <= '0;
            ldm_q        <= '0;
            inport_q     <= '0;
            reg_write_q  <= 1'b0;
            outport_en_q <= 1'b0;
            wb_sel_q     <= '0;
            rwa_q        <= '0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            op_pop_q     <= op_pop_d;
            low_q        <= low_d;
            mem_data_q   <= mem_data_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            result_q     <= result;
            ldm_q        <= LDM_value;
            inport_q     <= input_port;
            reg_write_q  <= reg_write & ~bubble;
            outport_en_q <= outport_enable & ~bubble;
            wb_sel_q     <= wb_sel;
            rwa_q        <= reg_write_address;
        end
    end

    assign pc_from_mem           = pc_q;
    assign pc_from_mem_valid     = pc_valid_q;
    assign mem_data_out          = mem_data_q;
    assign result_out            = result_q;
    assign LDM_value_out         = ldm_q;
    assign input_port_out        = inport_q;
    assign reg_write_out         = reg_write_q;
    assign outport_enable_out    = outport_en_q;
    assign wb_sel_out            = wb_sel_q;
    assign reg_write_address_out = rwa_q;
    assign sp_out                = sp_q;
    assign state_out             = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomised scoreboard bench for memory_stage with an instruction-level reference model.
`timescale 1ns/1ps
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result, read_data1, LDM_value, input_port;
    logic [31:0] pc_plus_one;
    logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic        reg_write, outport_enable;
    logic [2:0]  reg_write_address;
    logic        stall, pc_from_mem_valid, reg_write_out, outport_enable_out;
    logic [31:0] pc_from_mem;
    logic [15:0] mem_data_out, result_out, LDM_value_out, input_port_out;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;
    logic [AW-1:0] sp_out;
    mem_state_e  state_out;

    memory_stage #(.ADDR_W(AW), .SP_INIT(12'hFFF)) dut (
        .clk(clk), .reset(reset), .result(result), .read_data1(read_data1),
        .pc_plus_one(pc_plus_one), .mem_read(mem_read), .mem_write(mem_write),
        .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory), .reg_write(reg_write),
        .outport_enable(outport_enable), .wb_sel(wb_sel),
        .reg_write_address(reg_write_address), .LDM_value(LDM_value),
        .input_port(input_port), .stall(stall), .pc_from_mem(pc_from_mem),
        .pc_from_mem_valid(pc_from_mem_valid), .mem_data_out(mem_data_out),
        .result_out(result_out), .LDM_value_out(LDM_value_out),
        .input_port_out(input_port_out), .reg_write_out(reg_write_out),
        .outport_enable_out(outport_enable_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out), .sp_out(sp_out),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result, rd1, ldm, inp;
        logic [31:0] pc;
        logic        rd, wr, push, pop, pcc, rw, oe;
        logic [1:0]  asel, wsrc, wbs;
        logic [2:0]  rwa;
    } op_t;

    typedef struct {
        logic [15:0] mdo, res, ldm, inp;
        logic        rw, oe;
        logic [1:0]  wbs;
        logic [2:0]  rwa;
        logic [AW-1:0] sp;
        logic [31:0] pc;
        logic        pcv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: memory image and architectural registers of the stage.
    logic [15:0]   ref_mem [4096];
    logic [AW-1:0] m_sp;
    logic [15:0]   m_mdo;
    logic [31:0]   m_pc;
    logic          m_pcv;

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("mem_data_out", 32'(mem_data_out), 32'(mon_e.mdo));
            chk("result_out", 32'(result_out), 32'(mon_e.res));
            chk("LDM_value_out", 32'(LDM_value_out), 32'(mon_e.ldm));
            chk("input_port_out", 32'(input_port_out), 32'(mon_e.inp));
            chk("reg_write_out", 32'(reg_write_out), 32'(mon_e.rw));
            chk("outport_enable_out", 32'(outport_enable_out), 32'(mon_e.oe));
            chk("wb_sel_out", 32'(wb_sel_out), 32'(mon_e.wbs));
            chk("reg_write_address_out", 32'(reg_write_address_out), 32'(mon_e.rwa));
            chk("sp_out", 32'(sp_out), 32'(mon_e.sp));
            chk("pc_from_mem", pc_from_mem, mon_e.pc);
            chk("pc_from_mem_valid", 32'(pc_from_mem_valid), 32'(mon_e.pcv));
        end
    end

    task automatic drive(input op_t o);
        result = o.result; read_data1 = o.rd1; LDM_value = o.ldm; input_port = o.inp;
        pc_plus_one = o.pc; mem_read = o.rd; mem_write = o.wr; mem_push = o.push;
        mem_pop = o.pop; pc_choose_memory = o.pcc; reg_write = o.rw;
        outport_enable = o.oe; memory_address_select = o.asel;
        memory_write_src_select = o.wsrc; wb_sel = o.wbs; reg_write_address = o.rwa;
    endtask

    function automatic op_t blank_op();
        op_t o;
        o.result = $urandom(); o.rd1 = $urandom(); o.ldm = $urandom(); o.inp = $urandom();
        o.pc = $urandom(); o.rw = 1'($urandom_range(0, 1)); o.oe = 1'($urandom_range(0, 1));
        o.wbs = 2'($urandom_range(0, 3)); o.rwa = 3'($urandom_range(0, 7));
        o.rd = 0; o.wr = 0; o.push = 0; o.pop = 0; o.pcc = 0;
        o.asel = 2'b00; o.wsrc = 2'b00;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o = blank_op();
        o.push = ($urandom_range(0, 4) == 0);
        o.pop  = ($urandom_range(0, 3) == 0);
        o.wr   = ($urandom_range(0, 3) == 0);
        o.rd   = ($urandom_range(0, 2) == 0);
        o.pcc  = 1'($urandom_range(0, 1));
        if (o.push || o.pop) o.asel = 2'b01;
        else o.asel = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(2, 3));
        if (o.push) o.wsrc = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
        else o.wsrc = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(2, 3));
        return o;
    endfunction

    function automatic exp_t make_exp(input op_t o, input logic bub);
        exp_t e;
        e.mdo = m_mdo; e.res = o.result; e.ldm = o.ldm; e.inp = o.inp;
        e.rw = bub ? 1'b0 : o.rw; e.oe = bub ? 1'b0 : o.oe;
        e.wbs = o.wbs; e.rwa = o.rwa; e.sp = m_sp; e.pc = m_pc; e.pcv = m_pcv;
        return e;
    endfunction

    // Issues one instruction (one or two cycles) and queues its expected MEM/WB image.
    task automatic run_op(input op_t o);
        logic [15:0] lo;
        @(negedge clk);
        drive(o);
        m_pcv = 1'b0;
        if (o.push && o.wsrc == 2'b01) begin
            ref_mem[m_sp] = o.pc[31:16]; m_sp = m_sp - 1'b1;
            exp_q.push_back(make_exp(o, 1'b1));
            #1 chk("stall_word1", 32'(stall), 32'd1);
            @(negedge clk);
            ref_mem[m_sp] = o.pc[15:0]; m_sp = m_sp - 1'b1;
            exp_q.push_back(make_exp(o, 1'b0));
            #1 chk("stall_word2", 32'(stall), 32'd0);
        end else if (o.push) begin
            ref_mem[m_sp] = o.rd1; m_sp = m_sp - 1'b1;
            exp_q.push_back(make_exp(o, 1'b0));
            #1 chk("stall_single", 32'(stall), 32'd0);
        end else if (o.pop && o.pcc) begin
            m_sp = m_sp + 1'b1; lo = ref_mem[m_sp];
            exp_q.push_back(make_exp(o, 1'b1));
            #1 chk("stall_word1", 32'(stall), 32'd1);
            @(negedge clk);
            m_sp = m_sp + 1'b1; m_pc = {ref_mem[m_sp], lo}; m_pcv = 1'b1;
            exp_q.push_back(make_exp(o, 1'b0));
            #1 chk("stall_word2", 32'(stall), 32'd0);
        end else begin
            if (o.pop) begin
                m_sp = m_sp + 1'b1; m_mdo = ref_mem[m_sp];
            end else if (o.wr) begin
                ref_mem[o.result[AW-1:0]] = o.rd1;
            end else if (o.rd) begin
                m_mdo = ref_mem[o.result[AW-1:0]];
            end
            exp_q.push_back(make_exp(o, 1'b0));
            #1 chk("stall_single", 32'(stall), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sp"}, 32'(sp_out), 32'h0FFF);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_pcv"}, 32'(pc_from_mem_valid), 32'd0);
        chk({tag, "_pc"}, pc_from_mem, 32'd0);
        chk({tag, "_mdo"}, 32'(mem_data_out), 32'd0);
        chk({tag, "_res"}, 32'(result_out), 32'd0);
        chk({tag, "_ldm"}, 32'(LDM_value_out), 32'd0);
        chk({tag, "_inp"}, 32'(input_port_out), 32'd0);
        chk({tag, "_rw"}, 32'(reg_write_out), 32'd0);
        chk({tag, "_oe"}, 32'(outport_enable_out), 32'd0);
        chk({tag, "_wbs"}, 32'(wb_sel_out), 32'd0);
        chk({tag, "_rwa"}, 32'(reg_write_address_out), 32'd0);
    endtask

    initial begin
        op_t o;
        reset = 1'b0;
        drive(blank_op());
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        m_sp = 12'hFFF; m_mdo = '0; m_pc = '0; m_pcv = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Give every word a known value so later loads/pops have defined expectations.
        for (int a = 0; a < 4096; a++) begin
            o = blank_op(); o.wr = 1; o.result = 16'(a);
            run_op(o);
        end

        o = blank_op(); o.wr = 1; o.result = 16'h0010; o.rd1 = 16'hBEEF; run_op(o);
        o = blank_op(); o.rd = 1; o.result = 16'h0010; run_op(o);
        o = blank_op(); o.push = 1; o.asel = 2'b01; o.rd1 = 16'h1234; run_op(o);
        o = blank_op(); o.pop = 1; o.asel = 2'b01; run_op(o);
        o = blank_op(); o.push = 1; o.asel = 2'b01; o.wsrc = 2'b01; o.pc = 32'h0001_0042; run_op(o);
        o = blank_op(); o.rd = 1; o.result = 16'h0FFF; run_op(o);
        o = blank_op(); o.rd = 1; o.result = 16'h0FFE; run_op(o);
        o = blank_op(); o.pop = 1; o.pcc = 1; o.asel = 2'b01; run_op(o);
        o = blank_op(); run_op(o);
        // SP is back at 0xFFF: a plain pop wraps to 0x000.
        o = blank_op(); o.pop = 1; o.asel = 2'b01; run_op(o);
        o = blank_op(); o.push = 1; o.pop = 1; o.asel = 2'b01; run_op(o);
        // Back-to-back 32-bit ops with no gap.
        o = blank_op(); o.push = 1; o.asel = 2'b01; o.wsrc = 2'b01; run_op(o);
        o = blank_op(); o.pop = 1; o.pcc = 1; o.asel = 2'b01; run_op(o);

        for (int i = 0; i < 400; i++) run_op(rand_op());

        // Reset during SECOND of a 32-bit pop.
        o = blank_op(); o.push = 1; o.asel = 2'b01; o.wsrc = 2'b01; o.pc = 32'hCAFE_F00D; run_op(o);
        @(negedge clk);
        o = blank_op(); o.pop = 1; o.pcc = 1; o.asel = 2'b01;
        drive(o);
        m_pcv = 1'b0; m_sp = m_sp + 1'b1;
        exp_q.push_back(make_exp(o, 1'b1));
        #1 chk("abort_stall_word1", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_pulse", 32'(pc_from_mem_valid), 32'd0);
            chk("abort_sp_hold", 32'(sp_out), 32'h0FFF);
        end
        drive(blank_op());
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        reset = 1'b1;
        m_sp = 12'hFFF; m_mdo = '0; m_pc = '0; m_pcv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("post_abort_pcv", 32'(pc_from_mem_valid), 32'd0);
        end

        for (int i = 0; i < 100; i++) run_op(rand_op());

        @(negedge clk);
        drive(blank_op());
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
